int_sqrt_seq: RTL and testbench
===============================

INT_SQRT_SEQ -- requirements
Module: int_sqrt_seq

Interface
REQ-001 Parameter: count_width, default 4, root width; radicand width is 2*count_width.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  radicand present.
REQ-005 in_ready  output  1  block can accept a radicand.
REQ-006 radicand  input  2*count_width  unsigned value to root, e.g. count_squared from the squaring counter.
REQ-007 out_valid  output  1  root/remainder valid.
REQ-008 out_ready  input  1  consumer takes result.
REQ-009 root  output  count_width  floor(sqrt(radicand)).
REQ-010 remainder  output  count_width+1  radicand - root*root.

Function
REQ-011 FSM states SHALL be IDLE, CALC, DONE; reset state IDLE.
REQ-012 in_ready SHALL equal (state==IDLE); out_valid SHALL equal (state==DONE); both combinational from state.
REQ-013 Accept: on an edge with state IDLE and in_valid=1, radicand SHALL be captured into an internal shift register, partial root and remainder cleared, iteration counter loaded with count_width-1, state -> CALC.
REQ-014 IDLE with in_valid=0: hold; no state change.
REQ-015 CALC: each edge SHALL perform one restoring digit step: rem' = (rem<<2) | next two MSBs of radicand; trial = (root<<2)|1; if rem' >= trial then rem = rem'-trial, root = (root<<1)|1, else rem = rem', root = root<<1.
REQ-016 Internal remainder arithmetic SHALL be count_width+2 bits wide; no overflow or truncation permitted; final remainder fits count_width+1 bits.
REQ-017 Exactly count_width CALC steps; on the step with counter==0, state -> DONE.
REQ-018 Latency: out_valid SHALL go high exactly count_width cycles after the accept edge.
REQ-019 in_valid and radicand changes during CALC or DONE SHALL be ignored (in_ready=0).
REQ-020 DONE: root and remainder SHALL hold stable while out_ready=0 (indefinite backpressure).
REQ-021 DONE with out_ready=1: transfer occurs on that edge, state -> IDLE; no new accept in the same edge (one bubble cycle between transactions).
REQ-022 root and remainder outputs SHALL be registered and change only on the final CALC edge or reset.
REQ-023 Boundary: radicand 0 -> root 0, remainder 0; radicand all-ones -> root 2^count_width-1, remainder 2*(2^count_width-1).

Reset
REQ-024 reset SHALL take priority over all other inputs, including mid-CALC and in DONE; the operation in flight is discarded.
REQ-025 After reset: state IDLE, in_ready=1, out_valid=0, root=0, remainder=0, iteration counter=0.
REQ-026 First accept possible on the first edge after reset deasserts.

Structure
REQ-027 State typedef (IDLE/CALC/DONE enum) SHALL live in shared package mult_pkg for reuse by other multi-cycle arithmetic blocks.
REQ-028 Single-step arithmetic (REQ-015) SHALL be a combinational sub-module sqrt_step parameterised by count_width; int_sqrt_seq holds FSM, counter and registers.
REQ-029 No latches; single clock domain; no multipliers inferred.

Verification (count_width=4)
REQ-030 Accept radicand 50 -> out_valid after 4 cycles, root 7, remainder 1.
REQ-031 Radicand 0 -> root 0, remainder 0; radicand 255 -> root 15, remainder 30; radicand 225 -> root 15, remainder 0.
REQ-032 Hold out_ready=0 for 10 cycles in DONE, toggle radicand/in_valid meanwhile -> root/remainder unchanged, in_ready=0, then out_ready=1 -> IDLE next cycle.
REQ-033 Assert reset on second CALC cycle of radicand 200 -> next cycle IDLE, out_valid=0, root=0, remainder=0; subsequent radicand 16 -> root 4, remainder 0.
REQ-034 Chain with the squaring counter: for n=0..15 feed count_squared, always out_ready=1 -> root==n, remainder==0 each transaction; plus exhaustive 0..255 against a reference floor-sqrt model.

Source files
------------

// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the multi-cycle arithmetic blocks (square root,
// sequential multipliers and friends) that use the same
// accept / iterate / present handshake.
//
// Contents:
//    mc_state_e      - three-phase controller state (IDLE, CALC, DONE)
//    counterWidth()  - width needed for an iteration counter covering
//                      0 .. steps-1 (never narrower than one bit)
// -----------------------------------------------------------------------------
package mult_pkg;

   // Controller phases shared by every multi-cycle arithmetic block:
   // IDLE waits for an operand, CALC iterates, and DONE holds the result
   // until the consumer takes it.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } mc_state_e;

   // Returns the width needed for a down-counter that starts at steps-1.
   // A single-step block still gets a one-bit counter so that the
   // declarations stay legal.
   function automatic int counterWidth(input int steps);
      int width;
      width = 1;
      while ((1 << width) < steps) begin
         width++;
      end
      return width;
   endfunction

endpackage

// File: rtl/sqrt_step.sv
// -----------------------------------------------------------------------------
// sqrt_step
// One restoring digit step of the bit-serial integer square root. It is purely
// combinational. The caller supplies the running remainder, the partial root
// and the next two radicand bits, MSB pair first. It gets back the updated
// remainder and the partial root extended by one bit.
//
// Ports:
//    remIn    [count_width+1:0]  running remainder before this step
//    rootIn   [count_width-1:0]  partial root before this step
//    pairIn   [1:0]              next two radicand bits
//    remOut   [count_width+1:0]  running remainder after this step
//    rootOut  [count_width-1:0]  partial root after this step
// -----------------------------------------------------------------------------
module sqrt_step #(
   parameter int count_width = 4
) (
   input  logic [count_width+1:0] remIn,
   input  logic [count_width-1:0] rootIn,
   input  logic [1:0]             pairIn,
   output logic [count_width+1:0] remOut,
   output logic [count_width-1:0] rootOut
);

   logic [count_width+1:0] remShift;
   logic [count_width+1:0] trial;
   logic                   takeBit;

   // Before step k, where k is the number of root bits already produced, the
   // remainder is at most 2*(2^k - 1). At most count_width-1 bits have been
   // produced, so the shifted remainder and the trial value (root<<2)|1 are
   // both below 2^(count_width+2). Shifting within count_width+2 bits
   // therefore never drops a set bit.
   always_comb begin
      remShift = (remIn << 2) | {{count_width{1'b0}}, pairIn};
      trial    = {rootIn, 2'b01};
      takeBit  = (remShift >= trial);
   end

   // Restoring decision: subtract the trial value and append a 1 when the
   // trial fits. Otherwise keep the shifted remainder and append a 0.
   always_comb begin
      remOut  = remShift;
      rootOut = (rootIn << 1) | {{(count_width-1){1'b0}}, takeBit};
      if (takeBit) begin
         remOut = remShift - trial;
      end
   end

endmodule

// File: rtl/int_sqrt_seq.sv
// -----------------------------------------------------------------------------
// int_sqrt_seq
// Sequential integer square root. It accepts an unsigned radicand of width
// 2*count_width and produces root = floor(sqrt(radicand)) and
// remainder = radicand - root*root. The block runs one restoring step per
// clock, so the result appears exactly count_width cycles after the accept.
// The result is held until the consumer takes it.
//
// Ports:
//    clk        in   single clock, all state updates on the rising edge
//    reset      in   synchronous active-high reset; overrides everything
//    in_valid   in   a radicand is present
//    in_ready   out  block is idle and will accept a radicand
//    radicand   in   [2*count_width-1:0] unsigned value to root
//    out_valid  out  root/remainder are valid
//    out_ready  in   consumer takes the result
//    root       out  [count_width-1:0] floor(sqrt(radicand))
//    remainder  out  [count_width:0]   radicand - root*root
// -----------------------------------------------------------------------------
module int_sqrt_seq #(
   parameter int count_width = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2*count_width-1:0] radicand,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [count_width-1:0]   root,
   output logic [count_width:0]     remainder
);

   import mult_pkg::*;

   localparam int CntW = counterWidth(count_width);

   mc_state_e state_q, state_d;

   logic [2*count_width-1:0] radShift_q, radShift_d;
   logic [count_width-1:0]   rootAcc_q,  rootAcc_d;
   logic [count_width+1:0]   remAcc_q,   remAcc_d;
   logic [CntW-1:0]          iterCount_q, iterCount_d;
   logic [count_width-1:0]   rootOut_q,  rootOut_d;
   logic [count_width:0]     remOut_q,   remOut_d;

   logic [count_width+1:0]   stepRem;
   logic [count_width-1:0]   stepRoot;

   // The arithmetic for a single digit lives in its own block. The top level
   // only feeds it the top pair of the shifting radicand each cycle.
   sqrt_step #(
      .count_width (count_width)
   ) uStep (
      .remIn   (remAcc_q),
      .rootIn  (rootAcc_q),
      .pairIn  (radShift_q[2*count_width-1 -: 2]),
      .remOut  (stepRem),
      .rootOut (stepRoot)
   );

   // Next-state and handshake logic. Every register holds by default, and
   // the handshake outputs depend only on the current state. During CALC the
   // radicand is consumed two bits at a time from the top. The visible
   // result registers load only on the final step. As a result root and
   // remainder stay stable through DONE and IDLE until the next finished
   // computation or a reset.
   always_comb begin
      state_d     = state_q;
      radShift_d  = radShift_q;
      rootAcc_d   = rootAcc_q;
      remAcc_d    = remAcc_q;
      iterCount_d = iterCount_q;
      rootOut_d   = rootOut_q;
      remOut_d    = remOut_q;
      in_ready    = 1'b0;
      out_valid   = 1'b0;

      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               radShift_d  = radicand;
               rootAcc_d   = '0;
               remAcc_d    = '0;
               iterCount_d = CntW'(count_width - 1);
               state_d     = CALC;
            end
         end
         CALC: begin
            radShift_d = radShift_q << 2;
            rootAcc_d  = stepRoot;
            remAcc_d   = stepRem;
            if (iterCount_q == '0) begin
               rootOut_d = stepRoot;
               remOut_d  = stepRem[count_width:0];
               state_d   = DONE;
            end else begin
               iterCount_d = iterCount_q - CntW'(1);
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers. Reset wins over everything else and
   // discards any operation in flight, including the held result.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         radShift_q  <= '0;
         rootAcc_q   <= '0;
         remAcc_q    <= '0;
         iterCount_q <= '0;
         rootOut_q   <= '0;
         remOut_q    <= '0;
      end else begin
         state_q     <= state_d;
         radShift_q  <= radShift_d;
         rootAcc_q   <= rootAcc_d;
         remAcc_q    <= remAcc_d;
         iterCount_q <= iterCount_d;
         rootOut_q   <= rootOut_d;
         remOut_q    <= remOut_d;
      end
   end

   assign root      = rootOut_q;
   assign remainder = remOut_q;

endmodule

// File: tb/tb_int_sqrt_seq.sv
// -----------------------------------------------------------------------------
// tb_int_sqrt_seq
// Self-checking bench for int_sqrt_seq with count_width = 4. The expected root
// and remainder come from a plain floor-sqrt search. Each comparison is an
// immediate assertion that counts and reports failures.
// -----------------------------------------------------------------------------
module tb_int_sqrt_seq;

   localparam int CW = 4;

   logic          clk;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [2*CW-1:0] radicand;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] root;
   logic [CW:0]   remainder;

   int compareCount;
   int failCount;

   int_sqrt_seq #(
      .count_width (CW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .radicand  (radicand),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .root      (root),
      .remainder (remainder)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: the largest r with r*r <= x, found by counting up.
   function automatic int refRoot(input int x);
      int r;
      r = 0;
      while ((r + 1) * (r + 1) <= x) begin
         r++;
      end
      return r;
   endfunction

   function automatic int refRem(input int x);
      int r;
      r = refRoot(x);
      return x - r * r;
   endfunction

   // Advance one clock and sample just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One counted comparison.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compareCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Present a radicand for one edge while the block is idle, then drive
   // random junk on the radicand bus.
   task automatic applyStimulus(input string tag, input logic [2*CW-1:0] rad);
      checkOutput({tag, "_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      radicand = rad;
      tick();
      in_valid = 1'b0;
      radicand = 8'($urandom);
   endtask

   // Wait, with a bounded cycle budget, for out_valid. The caller may ask for
   // noise on in_valid/radicand during the wait, which the block must ignore.
   // The latency from the accept edge must be exactly CW cycles.
   task automatic waitDone(input string tag, input bit noise);
      int lat;
      lat = 0;
      while (!out_valid && lat < 20) begin
         checkOutput({tag, "_busyReady"}, 32'(in_ready), 32'd0);
         if (noise) begin
            in_valid = 1'($urandom);
            radicand = 8'($urandom);
         end
         tick();
         lat++;
      end
      in_valid = 1'b0;
      checkOutput({tag, "_latency"}, 32'(lat), 32'(CW));
   endtask

   // Full transaction: accept, compute, compare against the model, hand off
   // with out_ready and confirm the return to idle.
   task automatic runTxn(input string tag, input logic [2*CW-1:0] rad, input bit noise);
      applyStimulus(tag, rad);
      waitDone(tag, noise);
      checkOutput({tag, "_root"}, 32'(root), 32'(refRoot(int'(rad))));
      checkOutput({tag, "_rem"},  32'(remainder), 32'(refRem(int'(rad))));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checkOutput({tag, "_idleReady"}, 32'(in_ready), 32'd1);
      checkOutput({tag, "_idleValid"}, 32'(out_valid), 32'd0);
   endtask

   // Directed sequence followed by randomized and exhaustive sweeps.
   initial begin
      logic [CW-1:0] heldRoot;
      logic [CW:0]   heldRem;
      logic [2*CW-1:0] rad;

      compareCount = 0;
      failCount    = 0;
      reset     = 1'b1;
      in_valid  = 1'b0;
      radicand  = '0;
      out_ready = 1'b0;

      // Reset state.
      tick();
      tick();
      checkOutput("rst_inReady",  32'(in_ready),  32'd1);
      checkOutput("rst_outValid", 32'(out_valid), 32'd0);
      checkOutput("rst_root",     32'(root),      32'd0);
      checkOutput("rst_rem",      32'(remainder), 32'd0);

      // First accept on the first edge after reset deasserts.
      reset = 1'b0;
      runTxn("r50", 8'd50, 1'b1);

      // Boundary values.
      runTxn("r0",   8'd0,   1'b1);
      runTxn("r255", 8'd255, 1'b1);
      runTxn("r225", 8'd225, 1'b0);

      // Backpressure: hold the result for 10 cycles while noise is driven.
      rad = 8'($urandom);
      applyStimulus("bp", rad);
      waitDone("bp", 1'b0);
      heldRoot = root;
      heldRem  = remainder;
      checkOutput("bp_root", 32'(root), 32'(refRoot(int'(rad))));
      checkOutput("bp_rem",  32'(remainder), 32'(refRem(int'(rad))));
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'($urandom);
         radicand = 8'($urandom);
         tick();
         checkOutput("bp_holdRoot",  32'(root),      32'(heldRoot));
         checkOutput("bp_holdRem",   32'(remainder), 32'(heldRem));
         checkOutput("bp_holdReady", 32'(in_ready),  32'd0);
         checkOutput("bp_holdValid", 32'(out_valid), 32'd1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checkOutput("bp_releaseReady", 32'(in_ready),  32'd1);
      checkOutput("bp_releaseValid", 32'(out_valid), 32'd0);

      // Bubble: in_valid already high during the transfer edge is not taken
      // on that edge. It is taken one edge later.
      applyStimulus("bub", 8'd10);
      waitDone("bub", 1'b0);
      in_valid  = 1'b1;
      radicand  = 8'd81;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checkOutput("bub_idleReady", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      waitDone("bub81", 1'b0);
      checkOutput("bub81_root", 32'(root),      32'd9);
      checkOutput("bub81_rem",  32'(remainder), 32'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Reset during the second CALC cycle of radicand 200.
      applyStimulus("rc", 8'd200);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("rc_inReady",  32'(in_ready),  32'd1);
      checkOutput("rc_outValid", 32'(out_valid), 32'd0);
      checkOutput("rc_root",     32'(root),      32'd0);
      checkOutput("rc_rem",      32'(remainder), 32'd0);
      runTxn("r16", 8'd16, 1'b0);

      // Perfect squares n*n, as a squaring counter would produce them.
      for (int n = 0; n < 16; n++) begin
         applyStimulus("sq", 8'(n * n));
         waitDone("sq", 1'b0);
         checkOutput("sq_root", 32'(root),      32'(n));
         checkOutput("sq_rem",  32'(remainder), 32'd0);
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
      end

      // Random radicands with input noise during the computation.
      for (int i = 0; i < 20; i++) begin
         runTxn("rnd", 8'($urandom), 1'b1);
      end

      // Exhaustive sweep against the reference model.
      for (int x = 0; x < 256; x++) begin
         runTxn("exh", 8'(x), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
